// File: rtl/sipo_deserializer_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : sipo_deserializer_rx_if
//  Description : Signal bundle between a serial link source/parallel consumer
//                and the SIPO deserializer.
//                slave  - the deserializer's view (serial in, parallel out)
//                master - the driver/consumer view (serial out, parallel in)
//  Signals     : Enable_In, Frame_Start_In, Shift_Data_Signal_In,
//                Serial_Data_In, Data_Ready_In            (towards deserializer)
//                Parallel_Data_Out, Data_Valid_Out, Bit_Count_Out,
//                Overrun_Error_Out                        (from deserializer)
//  Revision    : 1.0 - initial release
// ============================================================================
interface sipo_deserializer_rx_if #(
    parameter int DATA_WIDTH = 4
);
    localparam int c_CNT_W = $clog2(DATA_WIDTH);

    logic                  Enable_In;
    logic                  Frame_Start_In;
    logic                  Shift_Data_Signal_In;
    logic                  Serial_Data_In;
    logic                  Data_Ready_In;
    logic [DATA_WIDTH-1:0] Parallel_Data_Out;
    logic                  Data_Valid_Out;
    logic [c_CNT_W-1:0]    Bit_Count_Out;
    logic                  Overrun_Error_Out;

    modport slave (
        input  Enable_In,
        input  Frame_Start_In,
        input  Shift_Data_Signal_In,
        input  Serial_Data_In,
        input  Data_Ready_In,
        output Parallel_Data_Out,
        output Data_Valid_Out,
        output Bit_Count_Out,
        output Overrun_Error_Out
    );

    modport master (
        output Enable_In,
        output Frame_Start_In,
        output Shift_Data_Signal_In,
        output Serial_Data_In,
        output Data_Ready_In,
        input  Parallel_Data_Out,
        input  Data_Valid_Out,
        input  Bit_Count_Out,
        input  Overrun_Error_Out
    );
endinterface
`default_nettype wire

// File: rtl/sipo_deserializer_rx.sv
`default_nettype none
// ============================================================================
//  Module      : sipo_deserializer_rx
//  Description : Serial-in parallel-out receiver. Samples one bit per strobe,
//                assembles DATA_WIDTH-bit words and hands them to a one-entry
//                output register with a valid/ready handshake. A completed
//                word arriving while the register is still occupied (and not
//                being drained) is dropped and flagged with a one-cycle
//                overrun pulse.
//  Ports       : Clk_In    - clock, all logic on the rising edge
//                Reset_In  - asynchronous active-low reset
//                bus       - sipo_deserializer_rx_if.slave (serial strobe/data,
//                            enable, frame resync, parallel word handshake,
//                            bit count, overrun flag)
//  Parameters  : DATA_WIDTH (>= 2), MSB_FIRST (1: first bit -> MSB)
//  Revision    : 1.0 - initial release
// ============================================================================
module sipo_deserializer_rx #(
    parameter int DATA_WIDTH = 4,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  wire logic             Clk_In,
    input  wire logic             Reset_In,
    sipo_deserializer_rx_if.slave bus
);

    localparam int                 c_CNT_W = $clog2(DATA_WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DATA_WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [DATA_WIDTH-1:0] r_sr;
    logic [c_CNT_W-1:0]    r_count;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_overrun;

    logic                  w_shift;
    logic                  w_frame;
    logic                  w_complete;
    logic [DATA_WIDTH-1:0] w_sr_base;
    logic [DATA_WIDTH-1:0] w_shifted;
    logic [DATA_WIDTH-1:0] w_sr_next;
    logic [c_CNT_W-1:0]    w_count_next;
    logic                  w_load;
    logic                  w_overrun;

    // Enable gates the serial side only; the consumer handshake stays live.
    assign w_shift = bus.Enable_In & bus.Shift_Data_Signal_In;
    assign w_frame = bus.Enable_In & bus.Frame_Start_In;

    // A resync restarts from an empty word, so a strobe in the same cycle
    // shifts into a cleared register and can never complete a word.
    assign w_sr_base  = w_frame ? '0 : r_sr;
    assign w_complete = w_shift & ~w_frame & (r_count == c_LAST);

    if (MSB_FIRST) begin : g_msb_first
        assign w_shifted = {w_sr_base[DATA_WIDTH-2:0], bus.Serial_Data_In};
    end else begin : g_lsb_first
        assign w_shifted = {bus.Serial_Data_In, w_sr_base[DATA_WIDTH-1:1]};
    end

    assign w_sr_next = w_shift ? w_shifted : w_sr_base;

    always_comb begin
        w_count_next = r_count;
        if (w_frame) begin
            w_count_next = w_shift ? c_ONE : '0;
        end else if (w_shift) begin
            w_count_next = (r_count == c_LAST) ? '0 : r_count + c_ONE;
        end
    end

    // Shift register and bit counter
    always_ff @(posedge Clk_In or negedge Reset_In) begin
        if (!Reset_In) begin
            r_sr    <= '0;
            r_count <= '0;
        end else if (w_shift || w_frame) begin
            r_sr    <= w_sr_next;
            r_count <= w_count_next;
        end
    end

    // Output state register
    always_ff @(posedge Clk_In or negedge Reset_In) begin
        if (!Reset_In) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Output next-state logic
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_overrun    = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_complete) begin
                    w_state_next = S_FULL;
                    w_load       = 1'b1;
                end
            end
            S_FULL: begin
                if (w_complete) begin
                    // Draining and refilling in one cycle is lossless;
                    // otherwise the held word wins and the new one is lost.
                    if (bus.Data_Ready_In) begin
                        w_load = 1'b1;
                    end else begin
                        w_overrun = 1'b1;
                    end
                end else if (bus.Data_Ready_In) begin
                    w_state_next = S_EMPTY;
                end
            end
            default: begin
                w_state_next = S_EMPTY;
            end
        endcase
    end

    // Output word register and registered overrun pulse
    always_ff @(posedge Clk_In or negedge Reset_In) begin
        if (!Reset_In) begin
            r_data    <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_overrun;
            if (w_load) begin
                r_data <= w_shifted;
            end
        end
    end

    assign bus.Parallel_Data_Out = r_data;
    assign bus.Data_Valid_Out    = (r_state == S_FULL);
    assign bus.Bit_Count_Out     = r_count;
    assign bus.Overrun_Error_Out = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sipo_deserializer_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sipo_deserializer_rx
//  Description : Self-checking bench for sipo_deserializer_rx. Two instances
//                (MSB-first and LSB-first) see identical stimulus; expected
//                words are queued when sent and compared when consumed.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sipo_deserializer_rx;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b1;
    logic fs    = 1'b0;
    logic sh    = 1'b0;
    logic sd    = 1'b0;
    logic rdy   = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;
    int ovr_m    = 0;
    int ovr_l    = 0;
    int ovr_exp  = 0;

    logic [3:0] q_m[$];
    logic [3:0] q_l[$];

    typedef struct {
        logic [3:0] bits;   // bits[3] is sent first
        logic [3:0] exp_m;  // word seen by the MSB-first instance
        logic [3:0] exp_l;  // word seen by the LSB-first instance
    } vec_t;
    vec_t tbl[9];

    always #5 clk = ~clk;

    sipo_deserializer_rx_if #(.DATA_WIDTH(4)) if_m ();
    sipo_deserializer_rx_if #(.DATA_WIDTH(4)) if_l ();

    assign if_m.Enable_In            = en;
    assign if_m.Frame_Start_In       = fs;
    assign if_m.Shift_Data_Signal_In = sh;
    assign if_m.Serial_Data_In       = sd;
    assign if_m.Data_Ready_In        = rdy;
    assign if_l.Enable_In            = en;
    assign if_l.Frame_Start_In       = fs;
    assign if_l.Shift_Data_Signal_In = sh;
    assign if_l.Serial_Data_In       = sd;
    assign if_l.Data_Ready_In        = rdy;

    sipo_deserializer_rx #(.DATA_WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
        .Clk_In   (clk),
        .Reset_In (rst_n),
        .bus      (if_m)
    );

    sipo_deserializer_rx #(.DATA_WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .Clk_In   (clk),
        .Reset_In (rst_n),
        .bus      (if_l)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Consumer side: a word is taken on the edge after a cycle with valid & ready.
    always @(negedge clk) begin
        if (rst_n && if_m.Data_Valid_Out && rdy) begin
            if (q_m.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL msb_unexpected_word: got %0h expected none", if_m.Parallel_Data_Out);
            end else begin
                check("msb_word", 32'(if_m.Parallel_Data_Out), 32'(q_m.pop_front()));
            end
        end
        if (rst_n && if_l.Data_Valid_Out && rdy) begin
            if (q_l.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL lsb_unexpected_word: got %0h expected none", if_l.Parallel_Data_Out);
            end else begin
                check("lsb_word", 32'(if_l.Parallel_Data_Out), 32'(q_l.pop_front()));
            end
        end
        if (if_m.Overrun_Error_Out) ovr_m++;
        if (if_l.Overrun_Error_Out) ovr_l++;
    end

    // Drive one cycle of inputs, ending 1 time unit after the capturing edge.
    task automatic step(input logic s, input logic d, input logic f);
        sh = s; sd = d; fs = f;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic send(input logic [3:0] bits);
        for (int i = 3; i >= 0; i--) step(1'b1, bits[i], 1'b0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_m_valid"}, 32'(if_m.Data_Valid_Out),    0);
        check({tag, "_m_data"},  32'(if_m.Parallel_Data_Out), 0);
        check({tag, "_m_count"}, 32'(if_m.Bit_Count_Out),     0);
        check({tag, "_m_ovr"},   32'(if_m.Overrun_Error_Out), 0);
        check({tag, "_l_valid"}, 32'(if_l.Data_Valid_Out),    0);
        check({tag, "_l_data"},  32'(if_l.Parallel_Data_Out), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{4'b1011, 4'hB, 4'hD};
        tbl[1] = '{4'b1100, 4'hC, 4'h3};
        tbl[2] = '{4'b0011, 4'h3, 4'hC};
        tbl[3] = '{4'b1010, 4'hA, 4'h5};
        tbl[4] = '{4'b0101, 4'h5, 4'hA};
        tbl[5] = '{4'b0000, 4'h0, 4'h0};
        tbl[6] = '{4'b1111, 4'hF, 4'hF};
        tbl[7] = '{4'b1000, 4'h8, 4'h1};
        tbl[8] = '{4'b0001, 4'h1, 4'h8};

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        check_zero("reset");
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single word, consumer ready: valid for exactly one cycle
        q_m.push_back(4'hB); q_l.push_back(4'hD);
        step(1'b1, 1'b1, 1'b0);
        check("count_after_1", 32'(if_m.Bit_Count_Out), 1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("count_after_3", 32'(if_m.Bit_Count_Out), 3);
        check("valid_before_last", 32'(if_m.Data_Valid_Out), 0);
        step(1'b1, 1'b1, 1'b0);
        check("t1_valid", 32'(if_m.Data_Valid_Out), 1);
        check("t1_data_m", 32'(if_m.Parallel_Data_Out), 32'hB);
        check("t1_data_l", 32'(if_l.Parallel_Data_Out), 32'hD);
        check("count_wrap", 32'(if_m.Bit_Count_Out), 0);
        idle(1);
        check("t1_valid_one_cycle", 32'(if_m.Data_Valid_Out), 0);

        // Table: back-to-back words with no bubble, no overrun expected
        for (int i = 0; i < 9; i++) begin
            q_m.push_back(tbl[i].exp_m);
            q_l.push_back(tbl[i].exp_l);
            send(tbl[i].bits);
            check("stream_valid", 32'(if_m.Data_Valid_Out), 1);
        end
        idle(2);
        check("stream_no_ovr_m", 32'(ovr_m), 32'(ovr_exp));
        check("stream_no_ovr_l", 32'(ovr_l), 32'(ovr_exp));

        // Overrun: consumer stalled, second word dropped
        rdy = 1'b0;
        q_m.push_back(4'hA); q_l.push_back(4'h5);
        send(4'b1010);
        send(4'b0101);
        check("ovr_pulse", 32'(if_m.Overrun_Error_Out), 1);
        check("ovr_hold_m", 32'(if_m.Parallel_Data_Out), 32'hA);
        check("ovr_hold_l", 32'(if_l.Parallel_Data_Out), 32'h5);
        ovr_exp++;
        idle(1);
        check("ovr_one_cycle", 32'(if_m.Overrun_Error_Out), 0);

        // Drain and refill in the same cycle: new word loaded, no pulse
        q_m.push_back(4'h5); q_l.push_back(4'hA);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        rdy = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        check("refill_no_ovr", 32'(if_m.Overrun_Error_Out), 0);
        check("refill_valid", 32'(if_m.Data_Valid_Out), 1);
        check("refill_data_m", 32'(if_m.Parallel_Data_Out), 32'h5);
        idle(2);
        check("ovr_count_m", 32'(ovr_m), 32'(ovr_exp));
        check("ovr_count_l", 32'(ovr_l), 32'(ovr_exp));

        // Frame resync with a coincident strobe
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        q_m.push_back(4'h9); q_l.push_back(4'h9);
        step(1'b1, 1'b1, 1'b1);
        check("resync_count", 32'(if_m.Bit_Count_Out), 1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("resync_data", 32'(if_m.Parallel_Data_Out), 32'h9);
        idle(2);

        // Enable low for 5 cycles with toggling strobes and a resync attempt
        q_m.push_back(4'hD); q_l.push_back(4'hB);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        en = 1'b0;
        for (int i = 0; i < 5; i++) step(1'(i % 2 == 0), 1'($urandom_range(1)), 1'(i == 2));
        check("disabled_count", 32'(if_m.Bit_Count_Out), 3);
        check("disabled_valid", 32'(if_m.Data_Valid_Out), 0);
        en = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        check("reenable_data_m", 32'(if_m.Parallel_Data_Out), 32'hD);
        check("reenable_data_l", 32'(if_l.Parallel_Data_Out), 32'hB);
        idle(2);

        // Async reset mid-word
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        sh = 1'b0;
        #3 rst_n = 1'b0;
        #1 check_zero("rst_midword");
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Async reset while a word is held
        rdy = 1'b0;
        send(4'b0011);
        check("held_before_rst", 32'(if_m.Data_Valid_Out), 1);
        sh = 1'b0;
        #3 rst_n = 1'b0;
        #1 check_zero("rst_held");
        q_m.delete(); q_l.delete();
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        rdy = 1'b1;
        q_m.push_back(4'hE); q_l.push_back(4'h7);
        send(4'b1110);
        check("post_rst_data", 32'(if_m.Parallel_Data_Out), 32'hE);
        idle(3);

        check("queue_m_empty", 32'(q_m.size()), 0);
        check("queue_l_empty", 32'(q_l.size()), 0);
        check("final_ovr_m", 32'(ovr_m), 32'(ovr_exp));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
